secuenciador_suma: RTL and testbench
====================================

# secuenciador_suma

Multi-word add/subtract sequencer that reuses a single N-bit ripple adder (`n_sumador_completo #(N)`) over W cycles to produce an N·W-bit result with full NZCV flags. It latches both wide operands on `start` and feeds the shared adder one word per cycle, least-significant word first. The carry is chained through a register between words. It sits between the control unit and the ALU adder datapath whenever operands exceed the adder width.

## Interface
- `N`, default 8: width of the shared adder, in bits per word.
- `W`, default 4: number of words per operand (W ≥ 2); total width is N·W.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request to begin an operation; sampled only when `busy`=0.
- `op`  in  1  operation select: 0 = A+B, 1 = A−B.
- `A`  in  N·W  first operand; sampled on the accepting edge.
- `B`  in  N·W  second operand; sampled on the accepting edge.
- `result`  out  N·W  sum or difference.
- `flag`  out  4  NZCV: [3]=N, [2]=Z, [1]=C, [0]=V.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when `result` and `flag` are final.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`=1.
  - RUN→DONE after the word with index W−1 is written.
  - DONE→IDLE unconditionally.
  - DONE→RUN instead when `start`=1 in DONE.
- On accept:
  - Latch A into `a_reg`.
  - Latch B into `b_reg`, bitwise inverted when `op`=1.
  - Set `carry_reg` = `op`.
  - Set word index `idx` = 0 and `zacc` = 1.
- Each RUN cycle:
  - Adder inputs are `a_reg` word `idx`, `b_reg` word `idx` and `carry_reg`.
  - The sum is written to `result` word `idx`.
  - `carry_reg` ← adder carry-out (adder flag[1]).
  - `zacc` ← `zacc` AND (sum == 0).
  - `idx` ← `idx`+1.
- On the last word (`idx`=W−1), `flag` is written:
  - N = sum[N−1].
  - Z = `zacc` AND (sum == 0).
  - C = adder carry-out. For subtraction C=1 means no borrow.
  - V = adder flag[0], which is the overflow of the top word.
- The adder's own flag[3:2] are ignored; N and Z are computed here.
- `result` words not yet written in the current operation hold stale data. `result` is valid only from the `done` cycle onward.
- `result` and `flag` hold their values until the next accepted operation overwrites them.
- `start` while `busy`=1 is ignored. `A`, `B` and `op` are don't-care after the accepting edge.

## Timing
- Reset values: state=IDLE, `result`=0, `flag`=4'b0000, `busy`=0, `done`=0. Internal `idx`, `carry_reg`, `a_reg`, `b_reg` and `zacc` are also cleared.
- Reset asserted mid-operation:
  - Immediate asynchronous return to the reset values above.
  - No `done` pulse for the aborted operation.
  - The first `start` after release of `rst_n` is accepted normally.
- Latency: with `start` accepted at edge k:
  - `busy`=1 after edges k+1 … k+W.
  - `done`=1, `busy`=0 after edge k+W+1, for exactly one cycle.
  - `result` and `flag` are valid in that same cycle.
- Throughput: back-to-back operations with `start` held in the DONE cycle give one result every W+1 cycles.
- The adder is purely combinational. The critical path is an N-bit ripple plus the zero detect, and must close within one clock.
- All outputs are registered; none is driven combinationally from inputs.

## Test plan
N=8, W=4 throughout.
1. Add 0x00000001 + 0xFFFFFFFF → `result`=0x00000000, `flag`=4'b0110. `done` occurs exactly 5 edges after the accepting edge.
2. Add 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `flag`=4'b1001.
3. Subtract 0x00000005 − 0x00000007 → `result`=0xFFFFFFFE, `flag`=4'b1000.
4. Subtract 0x12345678 − 0x12345678 → `result`=0x00000000, `flag`=4'b0110.
5. Pulse `start` with new operands during RUN → ignored, and the first result is unchanged. Then assert `rst_n`=0 during the 2nd RUN cycle → all outputs 0 immediately and no `done` pulse. After release, an add of 0x00000003 + 0x00000004 gives 0x00000007 with `flag`=4'b0000.
6. Hold `start` in the DONE cycle of an add of 0x80000000 + 0x80000000 (result 0x00000000, `flag`=4'b0111) to start a subtraction of 0x00000001 − 0x00000000 → second `done` arrives 5 cycles after the first, with 0x00000001 and `flag`=4'b0010.

Source files
------------

// File: rtl/secuenciador_suma.sv
// Multi-word add/subtract sequencer: one shared N-bit ripple adder is reused
// over W cycles, least-significant word first, to build an N*W-bit result with NZCV.

module n_sumador_completo #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic [3:0]   flag_o
);
    logic c_msb;
    logic c_out;

    always_comb begin
        logic carry;
        carry = cin_i;
        c_msb = cin_i;
        s_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) c_msb = carry;
            s_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        c_out = carry;
    end

    // Overflow is the carry into the sign bit disagreeing with the carry out.
    assign flag_o = {s_o[N-1], (s_o == '0), c_out, c_out ^ c_msb};
endmodule

module secuenciador_suma #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           op,
    input  logic [N*W-1:0] A,
    input  logic [N*W-1:0] B,
    output logic [N*W-1:0] result,
    output logic [3:0]     flag,
    output logic           busy,
    output logic           done
);
    localparam int             IW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]  LAST = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [N*W-1:0] a_q, b_q, result_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q, zacc_q, busy_q, done_q;
    logic [3:0]     flag_q;

    logic [N-1:0]   sum_d;
    logic [3:0]     add_flag_d;
    logic           zacc_d;
    logic           accept_d;

    n_sumador_completo #(.N(N)) u_adder (
        .a_i    (a_q[idx_q*N +: N]),
        .b_i    (b_q[idx_q*N +: N]),
        .cin_i  (carry_q),
        .s_o    (sum_d),
        .flag_o (add_flag_d)
    );

    // The adder's own N/Z only see one word; Z must span every word.
    assign zacc_d   = zacc_q & (sum_d == '0);
    assign accept_d = start && (state_q == IDLE || state_q == DONE);

    // busy/done are registered copies of the state, so they lag it by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            flag_q   <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_q == RUN);
            done_q <= (state_q == DONE);
            if (accept_d) begin
                a_q     <= A;
                b_q     <= op ? ~B : B;
                carry_q <= op;
                idx_q   <= '0;
                zacc_q  <= 1'b1;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        result_q[idx_q*N +: N] <= sum_d;
                        carry_q <= add_flag_d[1];
                        zacc_q  <= zacc_d;
                        idx_q   <= idx_q + IW'(1);
                        if (idx_q == LAST) begin
                            flag_q  <= {sum_d[N-1], zacc_d, add_flag_d[1], add_flag_d[0]};
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_secuenciador_suma.sv
// Bench for secuenciador_suma: arithmetic/timing reference model plus directed vectors.

module tb_secuenciador_suma;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int TW = N * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [TW-1:0] A = '0;
    logic [TW-1:0] B = '0;
    logic [TW-1:0] result;
    logic [3:0]    flag;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_pass  = 0;

    secuenciador_suma #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .result (result),
        .flag   (flag),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference arithmetic: plain wide add/subtract and textbook flag rules.
    task automatic ref_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic o,
                          output logic [TW-1:0] r, output logic [3:0] f);
        logic [TW:0] wide;
        logic        v;
        if (!o) wide = {1'b0, a} + {1'b0, b};
        else    wide = {1'b0, a} + {1'b0, ~b} + 1;
        r = wide[TW-1:0];
        if (!o) v = (a[TW-1] == b[TW-1]) && (r[TW-1] != a[TW-1]);
        else    v = (a[TW-1] != b[TW-1]) && (r[TW-1] != a[TW-1]);
        f = {r[TW-1], (r == '0), wide[TW], v};
    endtask

    // Timing model: m_cnt = edges since the accepting edge, -1 when nothing is pending.
    int            m_cnt = -1;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic [TW-1:0] e_res = '0;
    logic [3:0]    e_flag = '0;
    logic [TW-1:0] p_res = '0;
    logic [3:0]    p_flag = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = -1;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_res  = '0;
            e_flag = '0;
        end else begin
            logic acc;
            acc    = start && (m_cnt < 0 || m_cnt >= W);
            e_done = (m_cnt == W);
            if (e_done) begin
                e_res  = p_res;
                e_flag = p_flag;
            end
            if (acc) begin
                ref_op(A, B, op, p_res, p_flag);
                m_cnt = 0;
            end else if (m_cnt >= 0 && m_cnt <= W) m_cnt++;
            else m_cnt = -1;
            e_busy = (m_cnt >= 1 && m_cnt <= W);
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (e_done) begin
            chk("model_result", result, e_res);
            chk("model_flag", flag, e_flag);
        end
    end

    task automatic wait_done(output int edges);
        edges = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic o,
                          input logic [TW-1:0] xr, input logic [3:0] xf, input string nm);
        int edges;
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; op = ~o;
        wait_done(edges);
        chk({nm, "_latency"}, edges, W + 1);
        chk({nm, "_result"}, result, xr);
        chk({nm, "_flag"}, flag, xf);
    endtask

    initial begin
        int edges;
        int done_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 0);
        chk("reset_flag", flag, 4'b0000);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 4'b0110, "add_wrap");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b1000, "sub_borrow");
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0110, "sub_equal");

        // start pulsed during RUN must not disturb the running operation
        @(negedge clk);
        A = 32'h1111_1111; B = 32'h2222_2222; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 32'hAAAA_AAAA; B = 32'h0000_0001; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(edges);
        chk("ignore_start_seen", edges > 0, 1);
        chk("ignore_start_result", result, 32'h3333_3333);
        chk("ignore_start_flag", flag, 4'b0000);

        // asynchronous reset in the second RUN cycle
        @(negedge clk);
        A = 32'h0F0F_0F0F; B = 32'h0101_0101; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_result", result, 0);
        chk("abort_flag", flag, 4'b0000);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
            if (i == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        chk("abort_no_done", done_seen, 0);
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 4'b0000, "post_reset");

        // back-to-back: start held into the DONE cycle
        @(negedge clk);
        A = 32'h8000_0000; B = 32'h8000_0000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 32'h0000_0001; B = 32'h0000_0000; op = 1'b1;
        wait_done(edges);
        chk("b2b_first_latency", edges, W + 1);
        chk("b2b_first_result", result, 32'h0000_0000);
        chk("b2b_first_flag", flag, 4'b0111);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom; op = 1'b0;
        wait_done(edges);
        chk("b2b_spacing", edges, W + 1);
        chk("b2b_second_result", result, 32'h0000_0001);
        chk("b2b_second_flag", flag, 4'b0010);

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end
endmodule
